// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared pipeline definitions: writeback result-select encoding, load-format
// (funct3) codes, the default datapath width and the load-extension helper
// used by the writeback stage and the hazard unit.
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_NONE = 2'b11
  } wb_sel_e;

  localparam logic [2:0] FMT_LB  = 3'b000;
  localparam logic [2:0] FMT_LH  = 3'b001;
  localparam logic [2:0] FMT_LW  = 3'b010;
  localparam logic [2:0] FMT_LBU = 3'b100;
  localparam logic [2:0] FMT_LHU = 3'b101;

  // Extracts and extends a sub-word from an aligned 32-bit memory word.
  // Halfwords are selected by off[1] only; undefined codes behave as LW.
  function automatic logic [31:0] load_ext(input logic [2:0]  fmt,
                                           input logic [1:0]  off,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (fmt)
      FMT_LB:  r = {{24{b[7]}}, b};
      FMT_LH:  r = {{16{h[15]}}, h};
      FMT_LBU: r = {24'b0, b};
      FMT_LHU: r = {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_late_fifo.sv
// ---------------------------------------------------------------------------
// wb_late_fifo
// Small FIFO holding {rd, data} results from the multi-cycle unit until the
// writeback port has a free slot. The head is read combinationally so a
// drain decision can use it in the same cycle.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset (empties the FIFO)
//   push, din      enqueue request and entry (ignored while full)
//   pop            dequeue request (ignored while empty)
//   head           oldest entry
//   full, empty    status derived from the registered count
// ---------------------------------------------------------------------------
module wb_late_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_ptr_reg];

  // Storage carries no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop_ok)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
// Writeback stage: sole driver of the register-file write port. Registers
// the MEM/WB result (ALU, extended load, or PC+4) and merges multi-cycle
// results through a late-result FIFO so that at most one write occurs per
// cycle. The FIFO is drained when the pipeline offers nothing, or forcibly
// when it is full (the pipeline is then stalled through mem_ready).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mem_valid/mem_ready        MEM/WB handshake (mem_ready = !late_full)
//   mem_rd, mem_wb_sel         destination and result select
//   mem_alu_res, mem_pc4       ALU result, PC+4
//   mem_load_data/fmt/byte_off raw word, funct3, address[1:0]
//   late_valid/late_ready      multi-cycle result handshake
//   late_rd, late_data         multi-cycle destination and value
//   regD, write_data, regwrite register-file write port (registered)
// Optional (macro WB_FWD_EN):
//   fwd_valid, fwd_rd, fwd_data  next-edge values of the write port for the
//                                decode bypass
// Loads are taken from the low 32 bits of mem_load_data; XLEN >= 32.
// ---------------------------------------------------------------------------
module wb_stage #(
  parameter int XLEN       = pipe_pkg::XLEN_DEFAULT,
  parameter int LATE_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_valid,
  output logic            mem_ready,
  input  logic [4:0]      mem_rd,
  input  logic [1:0]      mem_wb_sel,
  input  logic [XLEN-1:0] mem_alu_res,
  input  logic [XLEN-1:0] mem_load_data,
  input  logic [2:0]      mem_load_fmt,
  input  logic [1:0]      mem_byte_off,
  input  logic [XLEN-1:0] mem_pc4,
  input  logic            late_valid,
  output logic            late_ready,
  input  logic [4:0]      late_rd,
  input  logic [XLEN-1:0] late_data,
  output logic [4:0]      regD,
  output logic [XLEN-1:0] write_data,
  output logic            regwrite
`ifdef WB_FWD_EN
  ,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data
`endif
);

  import pipe_pkg::*;

  localparam int EW = 5 + XLEN;

  logic            late_full;
  logic            late_empty;
  logic [EW-1:0]   head;
  logic            mem_xfer;
  logic            late_push;
  logic            drain;
  logic [31:0]     ext32;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] mem_result;
  logic            mem_we;

  logic [4:0]      regd_reg, regd_next;
  logic [XLEN-1:0] data_reg, data_next;
  logic            we_reg, we_next;

  assign mem_ready  = !late_full;
  assign late_ready = !late_full;
  assign mem_xfer   = mem_valid && mem_ready;
  assign late_push  = late_valid && late_ready;
  // A full FIFO forces a drain; mem_ready is low then, so it never collides
  // with a MEM transfer.
  assign drain      = !late_empty && (!mem_xfer || late_full);

  wb_late_fifo #(
    .DEPTH (LATE_DEPTH),
    .WIDTH (EW)
  ) u_late_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (late_push),
    .din   ({late_rd, late_data}),
    .pop   (drain),
    .head  (head),
    .full  (late_full),
    .empty (late_empty)
  );

  assign ext32 = load_ext(mem_load_fmt, mem_byte_off, mem_load_data[31:0]);

  generate
    if (XLEN > 32) begin : g_load_wide
      assign load_val = {{(XLEN-32){ext32[31]}}, ext32};
    end else begin : g_load_32
      assign load_val = ext32;
    end
  endgenerate

  always_comb begin
    mem_result = mem_alu_res;
    case (wb_sel_e'(mem_wb_sel))
      WB_LOAD: mem_result = load_val;
      WB_PC4:  mem_result = mem_pc4;
      default: mem_result = mem_alu_res;
    endcase
  end

  assign mem_we = (mem_rd != 5'd0) && (mem_wb_sel != WB_NONE);

  // Address/data hold when idle; suppressed writes still load them so the
  // slot is visibly consumed, but regwrite stays low.
  always_comb begin
    regd_next = regd_reg;
    data_next = data_reg;
    we_next   = 1'b0;
    if (drain) begin
      regd_next = head[EW-1 -: 5];
      data_next = head[XLEN-1:0];
      we_next   = (head[EW-1 -: 5] != 5'd0);
    end else if (mem_xfer) begin
      regd_next = mem_rd;
      data_next = mem_result;
      we_next   = mem_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regd_reg <= '0;
      data_reg <= '0;
      we_reg   <= 1'b0;
    end else begin
      regd_reg <= regd_next;
      data_reg <= data_next;
      we_reg   <= we_next;
    end
  end

  assign regD       = regd_reg;
  assign write_data = data_reg;
  assign regwrite   = we_reg;

`ifdef WB_FWD_EN
  assign fwd_valid = rst_n && we_next;
  assign fwd_rd    = regd_next;
  assign fwd_data  = data_next;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage
// Directed stimulus for wb_stage. Expected writes are queued in the order
// they must reach the register file; a negedge monitor pops and compares
// every regwrite pulse. Timing and handshake points are checked inline.
// ---------------------------------------------------------------------------
module tb_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [1:0]  mem_wb_sel;
  logic [31:0] mem_alu_res;
  logic [31:0] mem_load_data;
  logic [2:0]  mem_load_fmt;
  logic [1:0]  mem_byte_off;
  logic [31:0] mem_pc4;
  logic        late_valid;
  logic        late_ready;
  logic [4:0]  late_rd;
  logic [31:0] late_data;
  logic [4:0]  regD;
  logic [31:0] write_data;
  logic        regwrite;
`ifdef WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  wb_stage #(.XLEN(32), .LATE_DEPTH(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_rd        (mem_rd),
    .mem_wb_sel    (mem_wb_sel),
    .mem_alu_res   (mem_alu_res),
    .mem_load_data (mem_load_data),
    .mem_load_fmt  (mem_load_fmt),
    .mem_byte_off  (mem_byte_off),
    .mem_pc4       (mem_pc4),
    .late_valid    (late_valid),
    .late_ready    (late_ready),
    .late_rd       (late_rd),
    .late_data     (late_data),
    .regD          (regD),
    .write_data    (write_data),
    .regwrite      (regwrite)
`ifdef WB_FWD_EN
    ,
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_data      (fwd_data)
`endif
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic [4:0] rd, input logic [31:0] data);
    exp_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic mem_drive(input logic [4:0] rd, input logic [1:0] sel,
                           input logic [31:0] alu, input logic [31:0] ld,
                           input logic [2:0] fmt, input logic [1:0] off,
                           input logic [31:0] pc4);
    mem_valid     = 1'b1;
    mem_rd        = rd;
    mem_wb_sel    = sel;
    mem_alu_res   = alu;
    mem_load_data = ld;
    mem_load_fmt  = fmt;
    mem_byte_off  = off;
    mem_pc4       = pc4;
  endtask

  task automatic late_drive(input logic [4:0] rd, input logic [31:0] data);
    late_valid = 1'b1;
    late_rd    = rd;
    late_data  = data;
  endtask

  // Scoreboard monitor: every write pulse must match the next queued entry.
  always @(negedge clk) begin
    if (rst_n && regwrite) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=rd%0d/%h required=none t=%0t", regD, write_data, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("WRITE rd=%0d data=%h (expected rd=%0d data=%h) t=%0t", regD, write_data, e.rd, e.data, $time);
        chk("write_rd", {27'b0, regD}, {27'b0, e.rd});
        chk("write_data", write_data, e.data);
      end
    end
  end

`ifdef WB_FWD_EN
  logic        fv_prev;
  logic [4:0]  fr_prev;
  logic [31:0] fd_prev;
  bit          fprev_ok = 1'b0;

  always @(negedge clk) begin
    if (fprev_ok && rst_n) begin
      chk("fwd_valid", {31'b0, regwrite}, {31'b0, fv_prev});
      chk("fwd_rd", {27'b0, regD}, {27'b0, fr_prev});
      chk("fwd_data", write_data, fd_prev);
    end
    fv_prev  = fwd_valid;
    fr_prev  = fwd_rd;
    fd_prev  = fwd_data;
    fprev_ok = rst_n;
  end

  always @(negedge rst_n) fprev_ok = 1'b0;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    mem_valid     = 1'b0;
    mem_rd        = '0;
    mem_wb_sel    = 2'b00;
    mem_alu_res   = '0;
    mem_load_data = '0;
    mem_load_fmt  = 3'b010;
    mem_byte_off  = '0;
    mem_pc4       = '0;
    late_valid    = 1'b0;
    late_rd       = '0;
    late_data     = '0;

    // Reset state
    #1;
    chk("rst_regwrite", {31'b0, regwrite}, 32'd0);
    chk("rst_regD", {27'b0, regD}, 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_mem_ready", {31'b0, mem_ready}, 32'd1);
    chk("rst_late_ready", {31'b0, late_ready}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Load extension and result select
    mem_drive(5'd5, 2'b01, 32'h0, 32'h0000_8000, 3'b000, 2'd1, 32'h0);
    expect_write(5'd5, 32'hFFFF_FF80);
    step();
    chk("lb_timing_regwrite", {31'b0, regwrite}, 32'd1);
    chk("lb_timing_regD", {27'b0, regD}, 32'd5);
    mem_drive(5'd5, 2'b01, 32'h0, 32'h0000_8000, 3'b100, 2'd1, 32'h0);
    expect_write(5'd5, 32'h0000_0080);
    step();
    mem_drive(5'd6, 2'b01, 32'h0, 32'h8001_0000, 3'b001, 2'd2, 32'h0);
    expect_write(5'd6, 32'hFFFF_8001);
    step();
    mem_drive(5'd6, 2'b01, 32'h0, 32'h8001_0000, 3'b101, 2'd3, 32'h0);
    expect_write(5'd6, 32'h0000_8001);
    step();
    mem_drive(5'd4, 2'b01, 32'h0, 32'h7F00_0000, 3'b000, 2'd3, 32'h0);
    expect_write(5'd4, 32'h0000_007F);
    step();
    mem_drive(5'd8, 2'b01, 32'h0, 32'h8001_0000, 3'b010, 2'd3, 32'h0);
    expect_write(5'd8, 32'h8001_0000);
    step();
    mem_drive(5'd9, 2'b01, 32'h0, 32'hCAFE_F00D, 3'b011, 2'd1, 32'h0);
    expect_write(5'd9, 32'hCAFE_F00D);
    step();
    mem_drive(5'd10, 2'b10, 32'h0, 32'h0, 3'b010, 2'd0, 32'h0000_0104);
    expect_write(5'd10, 32'h0000_0104);
    step();

    // x0 and no-write suppression
    mem_drive(5'd0, 2'b00, 32'h0000_1234, 32'h0, 3'b010, 2'd0, 32'h0);
    step();
    chk("x0_regwrite", {31'b0, regwrite}, 32'd0);
    mem_drive(5'd1, 2'b00, 32'h0000_0055, 32'h0, 3'b010, 2'd0, 32'h0);
    expect_write(5'd1, 32'h0000_0055);
    step();
    chk("after_x0_regwrite", {31'b0, regwrite}, 32'd1);
    chk("after_x0_data", write_data, 32'h0000_0055);
    mem_drive(5'd3, 2'b11, 32'h0000_0999, 32'h0, 3'b010, 2'd0, 32'h0);
    step();
    chk("wbnone_regwrite", {31'b0, regwrite}, 32'd0);
    mem_valid = 1'b0;
    step();
    chk("idle_regwrite", {31'b0, regwrite}, 32'd0);

    // Idle late path: two-cycle latency, single pulse
    chk("late_ready_idle", {31'b0, late_ready}, 32'd1);
    late_drive(5'd7, 32'hDEAD_BEEF);
    expect_write(5'd7, 32'hDEAD_BEEF);
    step();
    late_valid = 1'b0;
    chk("late_n1_regwrite", {31'b0, regwrite}, 32'd0);
    step();
    chk("late_n2_regwrite", {31'b0, regwrite}, 32'd1);
    chk("late_n2_regD", {27'b0, regD}, 32'd7);
    step();
    chk("late_n3_regwrite", {31'b0, regwrite}, 32'd0);

    // Full FIFO under back-to-back MEM traffic. MEM wins while the FIFO has
    // room; once full, the head is forced out and MEM stalls. After one
    // drain the stall lifts, so the stalled instruction precedes late #2.
    mem_drive(5'd11, 2'b00, 32'h0000_0011, 32'h0, 3'b010, 2'd0, 32'h0);
    expect_write(5'd11, 32'h0000_0011);
    step();
    mem_drive(5'd12, 2'b00, 32'h0000_0012, 32'h0, 3'b010, 2'd0, 32'h0);
    expect_write(5'd12, 32'h0000_0012);
    late_drive(5'd20, 32'hA5A5_0001);
    step();
    mem_drive(5'd13, 2'b00, 32'h0000_0013, 32'h0, 3'b010, 2'd0, 32'h0);
    expect_write(5'd13, 32'h0000_0013);
    late_drive(5'd21, 32'hA5A5_0002);
    step();
    late_valid = 1'b0;
    chk("full_late_ready", {31'b0, late_ready}, 32'd0);
    chk("full_mem_ready", {31'b0, mem_ready}, 32'd0);
    mem_drive(5'd14, 2'b00, 32'h0000_0014, 32'h0, 3'b010, 2'd0, 32'h0);
    expect_write(5'd20, 32'hA5A5_0001);
    expect_write(5'd14, 32'h0000_0014);
    expect_write(5'd21, 32'hA5A5_0002);
    step();
    chk("drain1_regD", {27'b0, regD}, 32'd20);
    chk("drain1_mem_ready", {31'b0, mem_ready}, 32'd1);
    step();
    mem_valid = 1'b0;
    chk("stalled_regD", {27'b0, regD}, 32'd14);
    chk("stalled_data", write_data, 32'h0000_0014);
    step();
    chk("drain2_regD", {27'b0, regD}, 32'd21);
    chk("drain2_late_ready", {31'b0, late_ready}, 32'd1);
    step();
    chk("post_full_regwrite", {31'b0, regwrite}, 32'd0);

    // Reset mid-operation with one FIFO entry held and a write in flight
    mem_drive(5'd15, 2'b00, 32'h0000_0077, 32'h0, 3'b010, 2'd0, 32'h0);
    late_drive(5'd22, 32'h0000_0099);
    expect_write(5'd15, 32'h0000_0077);
    step();
    mem_valid  = 1'b0;
    late_valid = 1'b0;
    chk("prereset_regwrite", {31'b0, regwrite}, 32'd1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_regwrite", {31'b0, regwrite}, 32'd0);
    chk("midrst_regD", {27'b0, regD}, 32'd0);
    chk("midrst_write_data", write_data, 32'd0);
    chk("midrst_mem_ready", {31'b0, mem_ready}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("postrst_regwrite", {31'b0, regwrite}, 32'd0);
    end

    mem_drive(5'd2, 2'b00, 32'h0000_0002, 32'h0, 3'b010, 2'd0, 32'h0);
    expect_write(5'd2, 32'h0000_0002);
    step();
    mem_valid = 1'b0;
    chk("postrst_write", {31'b0, regwrite}, 32'd1);
    step();
    step();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
